// File: rtl/systolic_feed_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : systolic_feed_controller_if                               |
// | Description: Scheduler/datapath handshake bundle for the feed          |
// |              controller; ABORT exists only with SYSTOLIC_FEED_ABORT_EN. |
// | Revision   : 1.0                                                        |
// +------------------------------------------------------------------------+
interface systolic_feed_controller_if #(
    parameter int CNT_W = 16
) ();
    logic             START;
    logic [CNT_W-1:0] NUM_VECS;
    logic             STALL;
`ifdef SYSTOLIC_FEED_ABORT_EN
    logic             ABORT;
`endif
    logic             BUSY;
    logic             DONE;
    logic             RD_EN;
    logic [CNT_W-1:0] RD_ADDR;
    logic             SETUP_SYNC_RST;
    logic             SETUP_EN;
    logic             ZERO_SEL;

    modport master (
`ifdef SYSTOLIC_FEED_ABORT_EN
        output ABORT,
`endif
        output START, NUM_VECS, STALL,
        input  BUSY, DONE, RD_EN, RD_ADDR, SETUP_SYNC_RST, SETUP_EN, ZERO_SEL
    );

    modport slave (
`ifdef SYSTOLIC_FEED_ABORT_EN
        input  ABORT,
`endif
        input  START, NUM_VECS, STALL,
        output BUSY, DONE, RD_EN, RD_ADDR, SETUP_SYNC_RST, SETUP_EN, ZERO_SEL
    );
endinterface
`default_nettype wire

// File: rtl/systolic_feed_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : systolic_feed_controller                                  |
// | Description: Feeds one tile of K vectors through the skew stage, then  |
// |              flushes the diagonal and waits for the array to drain.    |
// |              Optional ABORT input under SYSTOLIC_FEED_ABORT_EN.         |
// | Revision   : 1.0                                                        |
// +------------------------------------------------------------------------+
module systolic_feed_controller #(
    parameter int LENGTH       = 256,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 256
) (
    input  wire logic                 CLK,
    input  wire logic                 ASYNC_RST,
    systolic_feed_controller_if.slave bus
);
    localparam int FL_W = (LENGTH > 2) ? $clog2(LENGTH - 1) : 1;
    localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [FL_W-1:0] c_FL_LAST = FL_W'((LENGTH > 1) ? LENGTH - 2 : 0);
    localparam logic [DR_W-1:0] c_DR_LAST = DR_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_FEED  = 3'd2;
    localparam logic [2:0] c_FLUSH = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;
    localparam logic [2:0] c_FIN   = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_k;
    logic [FL_W-1:0]  r_fl_cnt;
    logic [DR_W-1:0]  r_dr_cnt;
    logic             r_setup_en;
    logic             r_zero_sel;
    logic             r_abort_clr;
    logic             w_abort;
    logic             w_fire;
    logic             w_rd_last;
    logic             w_accept;

`ifdef SYSTOLIC_FEED_ABORT_EN
    assign w_abort = bus.ABORT & (r_state != c_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept  = (r_state == c_IDLE) & bus.START;
    assign w_fire    = (r_state == c_FEED) & ~bus.STALL;
    assign w_rd_last = (r_rd_cnt == (r_k - CNT_W'(1)));

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.START) w_next = (bus.NUM_VECS != '0) ? c_CLEAR : c_FIN;
            c_CLEAR: w_next = c_FEED;
            // A one-wide array has no diagonal to flush.
            c_FEED:  if (w_fire && w_rd_last) w_next = (LENGTH > 1) ? c_FLUSH : c_DRAIN;
            c_FLUSH: if (r_fl_cnt == c_FL_LAST) w_next = c_DRAIN;
            c_DRAIN: if (r_dr_cnt == c_DR_LAST) w_next = c_FIN;
            c_FIN:   w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
        if (w_abort) w_next = c_IDLE;
    end

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            r_state     <= c_IDLE;
            r_rd_cnt    <= '0;
            r_k         <= '0;
            r_fl_cnt    <= '0;
            r_dr_cnt    <= '0;
            r_setup_en  <= 1'b0;
            r_zero_sel  <= 1'b0;
            r_abort_clr <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_k      <= bus.NUM_VECS;
                r_rd_cnt <= '0;
            end else if (w_fire && !w_rd_last) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
            r_fl_cnt <= ((r_state == c_FLUSH) && (r_fl_cnt != c_FL_LAST)) ? r_fl_cnt + FL_W'(1) : '0;
            r_dr_cnt <= ((r_state == c_DRAIN) && (r_dr_cnt != c_DR_LAST)) ? r_dr_cnt + DR_W'(1) : '0;
            // Skew controls lag the read by one cycle to line up with read data.
            r_setup_en  <= ~w_abort & (w_fire | (r_state == c_FLUSH));
            r_zero_sel  <= ~w_abort & (r_state == c_FLUSH);
            r_abort_clr <= w_abort;
        end
    end

    assign bus.BUSY           = (r_state != c_IDLE);
    assign bus.DONE           = (r_state == c_FIN) & ~w_abort;
    assign bus.RD_EN          = (r_state == c_FEED);
    assign bus.RD_ADDR        = r_rd_cnt;
    assign bus.SETUP_SYNC_RST = (r_state == c_CLEAR) | r_abort_clr;
    assign bus.SETUP_EN       = r_setup_en;
    assign bus.ZERO_SEL       = r_zero_sel;
endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_systolic_feed_controller                               |
// | Description: Table, hand-sequence and randomized checks of the feed    |
// |              controller (LENGTH=4, DRAIN_CYCLES=3).                     |
// | Revision   : 1.0                                                        |
// +------------------------------------------------------------------------+
module tb_systolic_feed_controller;
    localparam int c_LEN = 4;
    localparam int c_DRN = 3;
    localparam int c_CW  = 16;

    logic CLK = 1'b0;
    logic ASYNC_RST;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    systolic_feed_controller_if #(.CNT_W(c_CW)) bus_if ();

    systolic_feed_controller #(
        .LENGTH      (c_LEN),
        .CNT_W       (c_CW),
        .DRAIN_CYCLES(c_DRN)
    ) dut (
        .CLK      (CLK),
        .ASYNC_RST(ASYNC_RST),
        .bus      (bus_if.slave)
    );

    typedef struct {
        int               k;
        int               ncyc;
        logic [63:0]      stall;
        logic [63:0]      rd_en;
        logic [63:0]      busy;
        logic [63:0]      srst;
        logic [63:0]      sen;
        logic [63:0]      zsel;
        logic [63:0]      done;
        logic [63:0][7:0] addr;
    } vec_t;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic blank(input int k, output vec_t v);
        v.k = k; v.ncyc = 4; v.stall = '0; v.rd_en = '0; v.busy = '0;
        v.srst = '0; v.sen = '0; v.zsel = '0; v.done = '0; v.addr = '0;
    endtask

    // Reference timeline: walk the reads one by one, then lay flush and drain after the last fire.
    task automatic model(input int k, input logic [63:0] stall, output vec_t e);
        int t, fired, f_last, d;
        blank(k, e);
        e.stall = stall;
        if (k == 0) begin
            e.busy[1] = 1'b1;
            e.done[1] = 1'b1;
            e.ncyc    = 4;
        end else begin
            e.srst[1] = 1'b1;
            t = 2;
            fired = 0;
            while (fired < k && t < 60) begin
                e.rd_en[t] = 1'b1;
                e.addr[t]  = 8'(fired);
                if (!stall[t]) begin
                    e.sen[t+1] = 1'b1;
                    fired++;
                end
                t++;
            end
            f_last = t - 1;
            for (int f = f_last + 1; f <= f_last + c_LEN - 1; f++) begin
                e.sen[f+1]  = 1'b1;
                e.zsel[f+1] = 1'b1;
            end
            d = f_last + c_LEN + c_DRN;
            e.done[d] = 1'b1;
            e.busy    = rng(1, d);
            e.ncyc    = d + 3;
        end
    endtask

    task automatic run_tile(input vec_t v, input string tag);
        for (int c = 0; c < v.ncyc; c++) begin
            @(negedge CLK);
            bus_if.START    = (c == 0);
            bus_if.NUM_VECS = c_CW'(v.k);
            bus_if.STALL    = v.stall[c];
            #1;
            chk({tag, ".busy"},  c, 32'(bus_if.BUSY),           32'(v.busy[c]));
            chk({tag, ".rd_en"}, c, 32'(bus_if.RD_EN),          32'(v.rd_en[c]));
            chk({tag, ".srst"},  c, 32'(bus_if.SETUP_SYNC_RST), 32'(v.srst[c]));
            chk({tag, ".sen"},   c, 32'(bus_if.SETUP_EN),       32'(v.sen[c]));
            chk({tag, ".zsel"},  c, 32'(bus_if.ZERO_SEL),       32'(v.zsel[c]));
            chk({tag, ".done"},  c, 32'(bus_if.DONE),           32'(v.done[c]));
            if (v.rd_en[c]) chk({tag, ".addr"}, c, 32'(bus_if.RD_ADDR), 32'(v.addr[c]));
        end
        bus_if.START = 1'b0;
        bus_if.STALL = 1'b0;
    endtask

    initial begin
        vec_t tbl [5];
        vec_t e;
        logic [63:0] st;

        // Hand-derived vectors.
        blank(2, tbl[0]);
        tbl[0].rd_en = rng(2, 3);  tbl[0].busy = rng(1, 10); tbl[0].srst = rng(1, 1);
        tbl[0].sen   = rng(3, 7);  tbl[0].zsel = rng(5, 7);  tbl[0].done = rng(10, 10);
        tbl[0].addr[2] = 8'd0; tbl[0].addr[3] = 8'd1; tbl[0].ncyc = 13;

        blank(3, tbl[1]);
        tbl[1].stall = rng(3, 4);
        tbl[1].rd_en = rng(2, 6);  tbl[1].busy = rng(1, 13); tbl[1].srst = rng(1, 1);
        tbl[1].sen   = rng(3, 3) | rng(6, 10); tbl[1].zsel = rng(8, 10); tbl[1].done = rng(13, 13);
        tbl[1].addr[2] = 8'd0; tbl[1].addr[3] = 8'd1; tbl[1].addr[4] = 8'd1;
        tbl[1].addr[5] = 8'd1; tbl[1].addr[6] = 8'd2; tbl[1].ncyc = 16;

        blank(0, tbl[2]);
        tbl[2].busy = rng(1, 1); tbl[2].done = rng(1, 1); tbl[2].ncyc = 4;

        blank(1, tbl[3]);
        tbl[3].rd_en = rng(2, 2); tbl[3].busy = rng(1, 9); tbl[3].srst = rng(1, 1);
        tbl[3].sen   = rng(3, 6); tbl[3].zsel = rng(4, 6); tbl[3].done = rng(9, 9);
        tbl[3].addr[2] = 8'd0; tbl[3].ncyc = 12;

        // Stall on the first FEED cycle plus stalls during FLUSH, which must be ignored.
        blank(1, tbl[4]);
        tbl[4].stall = rng(2, 2) | rng(4, 5);
        tbl[4].rd_en = rng(2, 3); tbl[4].busy = rng(1, 10); tbl[4].srst = rng(1, 1);
        tbl[4].sen   = rng(4, 7); tbl[4].zsel = rng(5, 7); tbl[4].done = rng(10, 10);
        tbl[4].addr[2] = 8'd0; tbl[4].addr[3] = 8'd0; tbl[4].ncyc = 13;

        ASYNC_RST       = 1'b1;
        bus_if.START    = 1'b0;
        bus_if.NUM_VECS = '0;
        bus_if.STALL    = 1'b0;
`ifdef SYSTOLIC_FEED_ABORT_EN
        bus_if.ABORT    = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        chk("rst.busy",  0, 32'(bus_if.BUSY),           0);
        chk("rst.done",  0, 32'(bus_if.DONE),           0);
        chk("rst.rd_en", 0, 32'(bus_if.RD_EN),          0);
        chk("rst.addr",  0, 32'(bus_if.RD_ADDR),        0);
        chk("rst.srst",  0, 32'(bus_if.SETUP_SYNC_RST), 0);
        chk("rst.sen",   0, 32'(bus_if.SETUP_EN),       0);
        chk("rst.zsel",  0, 32'(bus_if.ZERO_SEL),       0);
        ASYNC_RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 5; i++) run_tile(tbl[i], $sformatf("tbl%0d", i));

        // START re-asserted while busy is ignored; a later START is accepted.
        for (int c = 0; c < 24; c++) begin
            @(negedge CLK);
            bus_if.START    = (c == 0) || (c >= 4 && c <= 6) || (c == 11);
            bus_if.NUM_VECS = (c == 0) ? 16'd2 : ((c == 11) ? 16'd1 : 16'd0);
            #1;
            chk("restart.done", c, 32'(bus_if.DONE),           32'(c == 10 || c == 20));
            chk("restart.srst", c, 32'(bus_if.SETUP_SYNC_RST), 32'(c == 1 || c == 12));
        end
        bus_if.START = 1'b0;

        // Asynchronous reset mid-tile.
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            bus_if.START    = (c == 0);
            bus_if.NUM_VECS = 16'd2;
        end
        @(negedge CLK);
        bus_if.START = 1'b0;
        ASYNC_RST    = 1'b1;
        #1;
        chk("arst.busy",  5, 32'(bus_if.BUSY),           0);
        chk("arst.rd_en", 5, 32'(bus_if.RD_EN),          0);
        chk("arst.addr",  5, 32'(bus_if.RD_ADDR),        0);
        chk("arst.srst",  5, 32'(bus_if.SETUP_SYNC_RST), 0);
        chk("arst.sen",   5, 32'(bus_if.SETUP_EN),       0);
        chk("arst.zsel",  5, 32'(bus_if.ZERO_SEL),       0);
        chk("arst.done",  5, 32'(bus_if.DONE),           0);
        @(negedge CLK);
        ASYNC_RST = 1'b0;
        for (int c = 7; c < 16; c++) begin
            @(negedge CLK);
            #1;
            chk("arst.nodone", c, 32'(bus_if.DONE), 0);
            chk("arst.idle",   c, 32'(bus_if.BUSY), 0);
        end
        run_tile(tbl[0], "arst.after");

`ifdef SYSTOLIC_FEED_ABORT_EN
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            bus_if.START    = (c == 0);
            bus_if.NUM_VECS = 16'd2;
            bus_if.ABORT    = (c == 4);
            #1;
            chk("abort.done", c, 32'(bus_if.DONE), 0);
            if (c == 5) begin
                chk("abort.srst",  c, 32'(bus_if.SETUP_SYNC_RST), 1);
                chk("abort.busy",  c, 32'(bus_if.BUSY),           0);
                chk("abort.sen",   c, 32'(bus_if.SETUP_EN),       0);
                chk("abort.zsel",  c, 32'(bus_if.ZERO_SEL),       0);
                chk("abort.rd_en", c, 32'(bus_if.RD_EN),          0);
            end
            if (c == 6) chk("abort.srst_off", c, 32'(bus_if.SETUP_SYNC_RST), 0);
        end
        bus_if.START = 1'b0;
        bus_if.ABORT = 1'b0;
        run_tile(tbl[3], "abort.after");
`endif

        // Randomized tiles against the timeline model.
        for (int n = 0; n < 25; n++) begin
            st = '0;
            for (int c = 0; c < 40; c++) st[c] = ($urandom_range(0, 2) == 0);
            model(int'($urandom_range(0, 6)), st, e);
            run_tile(e, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/systolic_feed_controller.md
Name: systolic_feed_controller

Overview:
Sequences one tile of operand vectors from the activation buffer through the systolic skew (data setup) stage into the systolic array. It clears the skew registers, issues buffer reads, and steps the skew stage enable. It injects LENGTH-1 zero vectors to flush the diagonal, waits for the array pipeline to drain, then reports completion. It sits between the tile scheduler (START/DONE) and the buffer/skew-stage/array datapath.

Parameters:
LENGTH, 256, array dimension; skew stage depth is LENGTH-1.
CNT_W, 16, width of vector count and read address.
DRAIN_CYCLES, 256, cycles the array needs after the last skewed vector to complete.

Ports:
CLK  in  1  clock, rising edge.
ASYNC_RST  in  1  asynchronous reset, active-high.
START  in  1  begin tile; sampled only in IDLE.
NUM_VECS  in  CNT_W  number of vectors K in the tile; latched on accepted START.
STALL  in  1  buffer not ready; blocks read issue in FEED.
BUSY  out  1  high in every state except IDLE.
DONE  out  1  one-cycle completion pulse.
RD_EN  out  1  buffer read request.
RD_ADDR  out  CNT_W  buffer read address, 0..K-1.
SETUP_SYNC_RST  out  1  synchronous clear to the skew stage.
SETUP_EN  out  1  skew stage shift enable, aligned with buffer read data (1 cycle after the read fires).
ZERO_SEL  out  1  selects zero vector onto the skew stage inputs, aligned with SETUP_EN.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-tile aborts immediately; no DONE is produced.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, FIN.
- IDLE: START=1 and NUM_VECS!=0 -> CLEAR, latch K. START=1 and NUM_VECS==0 -> FIN, with no reads and no clear. START while BUSY is ignored.
- CLEAR: 1 cycle, SETUP_SYNC_RST=1, -> FEED.
- FEED: RD_EN=1, RD_ADDR=rd_cnt. fire = RD_EN & ~STALL; rd_cnt increments on fire. After the fire with rd_cnt==K-1 -> FLUSH. While STALL=1, RD_ADDR is held.
- FLUSH: exactly LENGTH-1 cycles, counted by fl_cnt. STALL is ignored. Each cycle is a zero step. -> DRAIN.
- DRAIN: exactly DRAIN_CYCLES cycles. -> FIN.
- FIN: 1 cycle, DONE=1, BUSY=1, -> IDLE.
- Registered outputs:
  - SETUP_EN(t+1) = fire(t) | (state(t)==FLUSH).
  - ZERO_SEL(t+1) = (state(t)==FLUSH).
  - SETUP_EN is therefore still high during the first DRAIN cycle.
- No-stall timing, with the START-accept cycle as cycle 0:
  - CLEAR at 1.
  - FEED at 2..K+1.
  - FLUSH at K+2..K+LENGTH.
  - DRAIN at K+LENGTH+1..K+LENGTH+DRAIN_CYCLES.
  - DONE at K+LENGTH+DRAIN_CYCLES+1.
  - Each STALL cycle in FEED adds one cycle to every later event.
- Counters: rd_cnt is CNT_W bits and never wraps (it stops at K-1). fl_cnt and the drain counter are sized by $clog2 of their limits. LENGTH==1 means zero FLUSH cycles (FEED -> DRAIN).

Optional Feature:
Macro SYSTOLIC_FEED_ABORT_EN.
- With the macro: adds input ABORT (1 bit). ABORT=1 in any non-IDLE state means:
  - the next state is IDLE;
  - SETUP_SYNC_RST pulses for 1 cycle;
  - RD_EN, SETUP_EN and ZERO_SEL are 0 from the next cycle;
  - no DONE is produced.
  - ABORT in IDLE has no effect. ABORT takes priority over every state transition, including FIN.
- Without the macro: no ABORT port exists, and a tile always runs to DONE.

Test Plan:
- LENGTH=4, DRAIN_CYCLES=3, K=2, no stall, START at cycle 0 -> SETUP_SYNC_RST at 1; RD_ADDR 0,1 at 2,3; SETUP_EN at 3..7; ZERO_SEL at 5..7; DONE at 10; BUSY at 1..10.
- Same config, K=3, STALL=1 at cycles 3 and 4 -> RD_ADDR holds 1 at 3..5; addr 2 at 6; SETUP_EN low at 4,5; DONE at 13.
- START with NUM_VECS=0 -> no RD_EN and no SETUP_SYNC_RST; DONE at cycle 1, then IDLE.
- START re-asserted at cycles 4..6 during the K=2 run -> ignored; exactly one DONE at 10; a new START at 11 is accepted.
- ASYNC_RST pulsed at cycle 5 of the K=2 run -> all outputs 0 immediately; no DONE; a fresh START after release gives nominal timing.
- With SYSTOLIC_FEED_ABORT_EN, ABORT at cycle 4 of the K=2 run -> SETUP_SYNC_RST=1 and BUSY=0 at 5; DONE never asserted; a subsequent K=1 tile completes normally.
